// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and state encoding for the multi-port register file
package regfile_mp_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Index of the hard-wired zero register when ZERO_REG is enabled.
    localparam int ZERO_REG_IDX  = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: zero-register, write bypass and storage select
//
// rs       : read address
// stored   : storage contents at rs
// wa_*/wb_*: write ports; the enables are already qualified (RUN state, zero-register drop)
// rd       : read data
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] stored,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_dest,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_dest,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rd
);

    // Port B is checked before port A so the bypass agrees with the
    // value that storage will hold after a same-address double write.
    always_comb begin
        rd = stored;
        if (ZERO_REG && (rs == AW'(ZERO_REG_IDX))) begin
            rd = '0;
        end else if (BYPASS && wb_en && (wb_dest == rs)) begin
            rd = wb_data;
        end else if (BYPASS && wa_en && (wa_dest == rs)) begin
            rd = wa_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file with two write ports, bypass and reset clear sweep
//
// clk, rst            : clock, synchronous active-high reset
// rs / rd             : NRD packed read addresses / read data, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
// wa_en/dest/data     : write port A
// wb_en/dest/data     : write port B, wins over A on equal address
// ready               : high once the clear sweep has zeroed every register
// wr_conflict         : one-cycle pulse after A and B wrote the same effective address
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_dest,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_dest,
    input  logic [XLEN-1:0]     wb_data,
    output logic                ready,
    output logic                wr_conflict
);

    rf_state_t       state;
    rf_state_t       state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            ready_next;
    logic            wa_eff;
    logic            wb_eff;
    logic            same_dest;
    logic [XLEN-1:0] regs [NREGS];

    // A write only counts in RUN, and a write to the zero register is
    // dropped entirely so it can neither update storage nor flag a conflict.
    always_comb begin
        wa_eff    = wa_en && (state == ST_RUN) &&
                    !(ZERO_REG && (wa_dest == AW'(ZERO_REG_IDX)));
        wb_eff    = wb_en && (state == ST_RUN) &&
                    !(ZERO_REG && (wb_dest == AW'(ZERO_REG_IDX)));
        same_dest = wa_eff && wb_eff && (wa_dest == wb_dest);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready;
        case (state)
            ST_CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == AW'(NREGS - 1)) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                end
            end
            ST_RUN: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            ready       <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            ready       <= ready_next;
            wr_conflict <= same_dest;
        end
    end

    // Storage has no reset of its own; the sweep zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                if (wa_eff && !same_dest) begin
                    regs[wa_dest] <= wa_data;
                end
                if (wb_eff) begin
                    regs[wb_dest] <= wb_data;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rd_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .rs      (rs[i*AW +: AW]),
            .stored  (regs[rs[i*AW +: AW]]),
            .wa_en   (wa_eff),
            .wa_dest (wa_dest),
            .wa_data (wa_data),
            .wb_en   (wb_eff),
            .wb_dest (wb_dest),
            .wb_data (wb_data),
            .rd      (rd[i*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write, two-read register file.
- Generalised in data width, register count, read-port count and write-port count (two write ports, fixed priority).
- Adds same-cycle write-to-read bypass and a reset clear sweep that zeroes every register.
- Asserts `ready` only after the sweep completes.
- Sits in the decode/writeback stage of the core; superscalar or ALU+load writeback uses both write ports.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2.
- AW, $clog2(NREGS), address width; derived, do not override.
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a read returns the same-cycle write data; 0 = a read returns the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- wa_en  in  1  write port A enable.
- wa_dest  in  AW  write port A address.
- wa_data  in  XLEN  write port A data.
- wb_en  in  1  write port B enable.
- wb_dest  in  AW  write port B address.
- wb_data  in  XLEN  write port B data.
- ready  out  1  high when the file is initialised and accepting writes.
- wr_conflict  out  1  registered pulse, one cycle after A and B wrote the same effective address.

Behaviour:
- The clock and reset are decided: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: CLEAR, RUN.
- rst=1 at any edge, including mid-sweep or mid-operation:
  - state <= CLEAR, clear counter <= 0.
  - ready <= 0, wr_conflict <= 0.
  - Writes on that edge are discarded.
- CLEAR state:
  - Each cycle writes 0 to registers[cnt], then cnt <= cnt+1.
  - On the edge that writes index NREGS-1: state <= RUN, ready <= 1.
  - The sweep takes exactly NREGS cycles after rst deasserts.
  - wa_en and wb_en are ignored (no storage update).
- RUN state: a write enable updates storage at the next edge.
- Write enable qualification:
  - With ZERO_REG=1, a write to address 0 is dropped; it does not set wr_conflict.
- Write port priority:
  - If both ports are enabled with equal dest, port B wins.
  - wr_conflict <= 1 for the following cycle, otherwise 0.
  - Different dests: both written on the same edge.
- Reads are combinational from rs and storage, evaluated per port i, in priority order:
  1. ZERO_REG=1 and rs_i==0 -> 0.
  2. BYPASS=1, state RUN, wb effective-enabled and wb_dest==rs_i -> wb_data.
  3. Else BYPASS=1, state RUN, wa effective-enabled and wa_dest==rs_i -> wa_data.
  4. Otherwise registers[rs_i].
- Reads during CLEAR return storage contents, which are undefined until swept. Consumers must gate on ready.
- Reset values of registered outputs: ready=0, wr_conflict=0. rd is combinational and has no reset value.
- No out-of-range addresses exist because NREGS is a power of two.

Decomposition:
- Shared core package holds:
  - XLEN and NREGS defaults.
  - The state encoding (CLEAR=1'b0, RUN=1'b1).
  - The ZERO_REG_IDX constant.
- One natural sub-module, regfile_rd_port: per-port zero/bypass/storage mux, instantiated NRD times in a generate loop.
- Storage, write logic and the clear FSM stay in the top module.

Test Plan:
- Assert rst for 1 cycle, then deassert -> ready=0 for exactly 32 cycles, then 1. Every register reads 0x00000000 afterwards.
- RUN: write A, reg5 <= 0xDEADBEEF; next cycle set rs0=5 -> rd0=0xDEADBEEF. Write reg0 <= 0x1234 -> rs1=0 reads 0 and wr_conflict stays 0.
- Same-cycle bypass: wa_en=1, wa_dest=7, wa_data=0xA5A5A5A5 with rs0=7 -> rd0=0xA5A5A5A5 in that cycle. With BYPASS=0 it returns the old value.
- Dual write with equal dest: A (reg9 <= 0x11) and B (reg9 <= 0x22) -> reg9 reads 0x22, wr_conflict=1 for exactly one cycle. Different dests 3/4 -> both written, no conflict.
- Reset mid-sweep: assert rst at sweep cycle 10 -> counter restarts at 0, ready rises 32 cycles after the second deassert. Write attempts during CLEAR leave storage at 0.
- Config sweep NREGS=16, NRD=4, XLEN=64, ZERO_REG=0 -> sweep lasts 16 cycles. Reg0 is writable with 0xFFFFFFFF_00000000. All four ports read independently.
